// File: rtl/operand_fwd_ctrl_if.sv
// ID-stage decode fields in, operand-mux selects, stall and stall count out.
// master: ID/decode side, slave: forwarding controller.
interface operand_fwd_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 16
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_use_imm;
  logic            id_wreg;
  logic [REGW-1:0] id_rn;
  logic            id_m2reg;
  logic            mem_stall;
  logic [2:0]      fwda;
  logic [2:0]      fwdb;
  logic            stall;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt, id_use_imm,
    output id_wreg, id_rn, id_m2reg,
    output mem_stall,
    input  fwda, fwdb, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt, id_use_imm,
    input  id_wreg, id_rn, id_m2reg,
    input  mem_stall,
    output fwda, fwdb, stall, stall_cnt
  );
endinterface

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding + load-use interlock. Ports: clock, resetn (async low),
// bus (slave): ID decode fields/mem_stall in; fwda, fwdb, stall, stall_cnt out.
module operand_fwd_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic              clock,
  input  logic              resetn,
  operand_fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic            wreg;
    logic [REGW-1:0] rn;
    logic            m2reg;
  } stage_t;

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_EXE = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_LD  = 3'b011;
  localparam logic [2:0] SEL_WB  = 3'b100;
  localparam logic [2:0] SEL_IMM = 3'b101;

  stage_t          e_q, m_q, w_q;
  stage_t          e_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [2:0] sel_a, sel_b;
  logic       lu_a, lu_b;
  logic       stall;

  // {load_use, select}; nearest stage wins, r0 never matches.
  function automatic logic [3:0] pick(
    input logic [REGW-1:0] r,
    input logic            use_r,
    input stage_t          e,
    input stage_t          m,
    input stage_t          w
  );
    logic he, hm, hw;
    logic [3:0] res;
    he  = use_r && (r != '0) && e.wreg && (e.rn == r);
    hm  = use_r && (r != '0) && m.wreg && (m.rn == r);
    hw  = use_r && (r != '0) && w.wreg && (w.rn == r);
    res = {1'b0, SEL_RF};
    priority case (1'b1)
      he:      res = e.m2reg ? {1'b1, SEL_RF} : {1'b0, SEL_EXE};
      hm:      res = m.m2reg ? {1'b0, SEL_LD} : {1'b0, SEL_MEM};
      hw:      res = {1'b0, SEL_WB};
      default: res = {1'b0, SEL_RF};
    endcase
    return res;
  endfunction

  always_comb begin
    {lu_a, sel_a} = pick(bus.id_rs, bus.id_use_rs, e_q, m_q, w_q);
    {lu_b, sel_b} = pick(bus.id_rt, bus.id_use_rt, e_q, m_q, w_q);
    if (bus.id_use_imm) begin
      sel_b = SEL_IMM;
      lu_b  = 1'b0;
    end
    stall = bus.id_valid & ~bus.mem_stall & (lu_a | lu_b);
  end

  always_comb begin
    e_d = '0;
    if (bus.id_valid && !stall)
      e_d = '{wreg: bus.id_wreg, rn: bus.id_rn, m2reg: bus.id_m2reg};
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else if (!bus.mem_stall) begin
      w_q   <= m_q;
      m_q   <= e_q;
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwda      = sel_a;
  assign bus.fwdb      = sel_b;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl (CNTW=2 to reach saturation).
// Each step drives ID fields, pushes expectations, then compares pre-edge.
module tb_operand_fwd_ctrl;

  localparam int REGW = 5;
  localparam int CNTW = 2;

  typedef struct {
    logic            v;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic            urs;
    logic            urt;
    logic            uimm;
    logic            wr;
    logic [REGW-1:0] rn;
    logic            m2;
    logic            ms;
    logic [2:0]      fa;
    logic [2:0]      fb;
    logic            st;
  } step_t;

  typedef logic [6+1+CNTW-1:0] obs_t;

  logic clk;
  logic resetn;

  operand_fwd_ctrl_if #(.REGW(REGW), .CNTW(CNTW)) bus ();

  operand_fwd_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [CNTW-1:0] exp_cnt;
  obs_t sb[$];

  function automatic step_t mk(
    input logic v, input int rs, input int rt,
    input logic urs, input logic urt, input logic uimm,
    input logic wr, input int rn, input logic m2,
    input logic ms,
    input logic [2:0] fa, input logic [2:0] fb, input logic st
  );
    step_t s;
    s.v = v; s.rs = rs[REGW-1:0]; s.rt = rt[REGW-1:0];
    s.urs = urs; s.urt = urt; s.uimm = uimm;
    s.wr = wr; s.rn = rn[REGW-1:0]; s.m2 = m2; s.ms = ms;
    s.fa = fa; s.fb = fb; s.st = st;
    return s;
  endfunction

  // Drive one ID cycle and push what must appear before the next edge.
  task automatic drive(input step_t s);
    bus.id_valid   = s.v;
    bus.id_rs      = s.rs;
    bus.id_rt      = s.rt;
    bus.id_use_rs  = s.urs;
    bus.id_use_rt  = s.urt;
    bus.id_use_imm = s.uimm;
    bus.id_wreg    = s.wr;
    bus.id_rn      = s.rn;
    bus.id_m2reg   = s.m2;
    bus.mem_stall  = s.ms;
    sb.push_back({s.fa, s.fb, s.st, exp_cnt});
    if (s.st && exp_cnt != {CNTW{1'b1}})
      exp_cnt = exp_cnt + 1'b1;
  endtask

  function automatic obs_t observe();
    return {bus.fwda, bus.fwdb, bus.stall, bus.stall_cnt};
  endfunction

  task automatic test_reset();
    obs_t e, g;
    resetn  = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    drive(mk(1, 5, 5, 1, 1, 1, 0, 0, 0, 0, 3'b000, 3'b101, 0));
    #1;
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset: got %b want %b", g, e);
    end
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    step_t t[5];
    obs_t e, g;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 3'b000, 3'b000, 0);
    t[1] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 0);
    t[2] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 3'b010, 3'b000, 0);
    t[3] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0);
    t[4] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b want %b", i, g, e);
      end
    end
  endtask

  task automatic test_load_use();
    step_t t[4];
    obs_t e, g;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 3'b000, 3'b000, 0);
    t[1] = mk(1, 0, 8, 0, 1, 0, 1, 9, 0, 0, 3'b000, 3'b000, 1);
    t[2] = mk(1, 0, 8, 0, 1, 0, 1, 9, 0, 0, 3'b000, 3'b011, 0);
    t[3] = mk(1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 3'b100, 3'b001, 0);
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL loaduse[%0d]: got %b want %b", i, g, e);
      end
    end
  endtask

  task automatic test_zero_imm();
    step_t t[3];
    obs_t e, g;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'b000, 3'b000, 0);
    t[1] = mk(1, 0, 0, 1, 0, 0, 1, 7, 1, 0, 3'b000, 3'b000, 0);
    t[2] = mk(1, 7, 7, 0, 1, 1, 0, 0, 0, 0, 3'b000, 3'b101, 0);
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL zeroimm[%0d]: got %b want %b", i, g, e);
      end
    end
  endtask

  task automatic test_priority();
    step_t t[5];
    obs_t e, g;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 3'b000, 3'b000, 0);
    t[1] = mk(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 3'b000, 3'b000, 0);
    t[2] = mk(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 0);
    t[3] = mk(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 3'b010, 3'b010, 0);
    t[4] = mk(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 3'b100, 3'b100, 0);
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL prio[%0d]: got %b want %b", i, g, e);
      end
    end
  endtask

  task automatic test_mem_stall();
    step_t t[6];
    obs_t e, g;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 3'b000, 3'b000, 0);
    t[1] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0);
    t[2] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0);
    t[3] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0);
    t[4] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
    t[5] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 3'b011, 3'b011, 0);
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL memstall[%0d]: got %b want %b", i, g, e);
      end
    end
  endtask

  task automatic test_saturation();
    step_t t[12];
    obs_t e, g;
    @(negedge clk);
    resetn  = 1'b0;
    exp_cnt = '0;
    #1;
    resetn = 1'b1;
    t[0] = mk(1, 0, 0, 0, 0, 0, 1, 10, 1, 0, 3'b000, 3'b000, 0);
    for (int i = 1; i < 12; i++) begin
      if (i % 2 == 1)
        t[i] = mk(1, 10, 0, 1, 0, 0, 1, 10, 1, 0, 3'b000, 3'b000, 1);
      else
        t[i] = mk(1, 10, 0, 1, 0, 0, 1, 10, 1, 0, 3'b011, 3'b000, 0);
    end
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sat[%0d]: got %b want %b", i, g, e);
      end
    end
    @(negedge clk);
    resetn  = 1'b0;
    exp_cnt = '0;
    drive(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    #1;
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL rstpulse: got %b want %b", g, e);
    end
    resetn = 1'b1;
    @(negedge clk);
    drive(mk(1, 10, 10, 1, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    #1;
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL postrst: got %b want %b", g, e);
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_use_rs  = 1'b0;
    bus.id_use_rt  = 1'b0;
    bus.id_use_imm = 1'b0;
    bus.id_wreg    = 1'b0;
    bus.id_rn      = '0;
    bus.id_m2reg   = 1'b0;
    bus.mem_stall  = 1'b0;
    exp_cnt        = '0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_imm();
    test_priority();
    test_mem_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
